// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
// The state encoding is also used by anything that snoops the sequencer state.
package pll_seq_pkg;

  localparam int LOSS_CNT_W = 8;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } seq_state_e;

  // Each counter load is (cycles - 1), so $clog2 of the largest value is enough.
  // The result is never less than 1 bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser that brings the asynchronous PLL lock flag into refclk.
// Both flops clear to 0 on rst, so the sequencer sees "not locked" until real samples arrive.
module pll_lock_sync (
  input  logic refclk,
  input  logic rst,
  input  logic locked,
  output logic locked_s
);

  logic meta;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      meta     <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      meta     <= locked;
      locked_s <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences the PLL reset and the downstream system reset from the PLL lock status.
// Define PLL_RESET_SEQ_RETRY_EN to retry failed lock attempts before declaring FAULT.
//
// state     | meaning
// RESET_PLL | pll_rst pulse in progress
// WAIT_LOCK | PLL released; waiting for locked_s, with a timeout
// STABLE    | locked_s seen; it must stay high for LOCK_STABLE_CYCLES
// RUN       | system released (sys_rst=0, ready=1)
// FAULT     | no lock within the allowed attempts; held until restart
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  restart,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic                  sys_rst,
  output logic                  ready,
  output logic                  fault,
  output logic [1:0]            attempt_cnt,
  output logic [LOSS_CNT_W-1:0] loss_cnt
);

  localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam logic [CW-1:0] PULSE_LD   = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LD = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LD  = CW'(LOCK_STABLE_CYCLES - 1);
`ifdef PLL_RESET_SEQ_RETRY_EN
  localparam int RETRY_LIMIT = MAX_RETRIES;
`else
  // With retries disabled, the first failed attempt always exceeds the limit.
  localparam int RETRY_LIMIT = 0 * MAX_RETRIES;
`endif

  seq_state_e            state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [1:0]            attempt_nxt;
  logic [LOSS_CNT_W-1:0] loss_nxt;
  logic [2:0]            fail_cnt;
  logic                  locked_s;

  pll_lock_sync u_sync (
    .refclk   (refclk),
    .rst      (rst),
    .locked   (pll_locked),
    .locked_s (locked_s)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    attempt_nxt = attempt_cnt;
    loss_nxt    = loss_cnt;
    fail_cnt    = {1'b0, attempt_cnt} + 3'd1;
    if (restart) begin
      state_nxt   = RESET_PLL;
      cnt_nxt     = PULSE_LD;
      attempt_nxt = '0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (cnt == '0) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = TIMEOUT_LD;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        WAIT_LOCK: begin
          // A lock on the last timeout cycle still counts as a lock.
          if (locked_s) begin
            state_nxt = STABLE;
            cnt_nxt   = STABLE_LD;
          end else if (cnt == '0) begin
            attempt_nxt = (fail_cnt > 3'd3) ? 2'd3 : fail_cnt[1:0];
            if (int'(fail_cnt) > RETRY_LIMIT) begin
              state_nxt = FAULT;
            end else begin
              state_nxt = RESET_PLL;
              cnt_nxt   = PULSE_LD;
            end
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = TIMEOUT_LD;
          end else if (cnt == '0) begin
            state_nxt = RUN;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_nxt = RESET_PLL;
            cnt_nxt   = PULSE_LD;
            if (loss_cnt != '1) loss_nxt = loss_cnt + 1'b1;
          end
        end
        FAULT: ;
        default: begin
          state_nxt = RESET_PLL;
          cnt_nxt   = PULSE_LD;
        end
      endcase
    end
    if (state_nxt == RUN) attempt_nxt = '0;
  end

  // Outputs are registered from the next state, so they change on the same edge as the state.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state       <= RESET_PLL;
      cnt         <= PULSE_LD;
      attempt_cnt <= '0;
      loss_cnt    <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      attempt_cnt <= attempt_nxt;
      loss_cnt    <= loss_nxt;
      pll_rst     <= (state_nxt == RESET_PLL) || (state_nxt == FAULT);
      sys_rst     <= (state_nxt != RUN);
      ready       <= (state_nxt == RUN);
      fault       <= (state_nxt == FAULT);
    end
  end

endmodule
